// File: rtl/controle_pisca_7seg_pkg.sv
// rtl/controle_pisca_7seg_pkg.sv - segment constants and blink FSM encoding
package controle_pisca_7seg_pkg;

  // Active-low segments, bit 6 = g ... bit 0 = a
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;
  localparam logic [6:0] SEG_APAGADO = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_APAGADO = 2'd1,
    ST_ACESO   = 2'd2
  } estado_t;

endpackage

// File: rtl/controle_pisca_7seg_decodificador.sv
// rtl/controle_pisca_7seg_decodificador.sv - combinational hex to seven-segment decoder
module decodificador_7seg
  import controle_pisca_7seg_pkg::*;
(
  input  logic [3:0] i_digito,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_APAGADO;
    case (i_digito)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
      default: o_seg = SEG_APAGADO;
    endcase
  end

endmodule

// File: rtl/controle_pisca_7seg.sv
// rtl/controle_pisca_7seg.sv - digit latch and blink sequencer driving the 7-segment 2:1 mux
module controle_pisca_7seg
  import controle_pisca_7seg_pkg::*;
#(
  parameter int P_DIV    = 25_000_000,
  parameter int P_NPISCA = 3
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] dado,
  input  logic       pisca_req,
  input  logic       pisca_stop,
  output logic [6:0] seg_dado,
  output logic [6:0] seg_apagado,
  output logic       sel,
  output logic       ocupado
);

  localparam int W_FASE  = (P_DIV > 1) ? $clog2(P_DIV) : 1;
  localparam int W_PISCA = (P_NPISCA > 0) ? $clog2(P_NPISCA + 1) : 1;
  localparam logic [W_FASE-1:0]  L_FASE_FIM  = W_FASE'(P_DIV - 1);
  localparam logic [W_PISCA-1:0] L_PISCA_FIM = (P_NPISCA > 0) ? W_PISCA'(P_NPISCA - 1) : '0;

  estado_t             r_estado;
  logic [W_FASE-1:0]   r_fase;
  logic [W_PISCA-1:0]  r_pisca;
  logic [3:0]          r_digito;
  logic [6:0]          w_seg;

  decodificador_7seg u_decod (
    .i_digito (r_digito),
    .o_seg    (w_seg)
  );

  assign seg_apagado = SEG_APAGADO;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_digito <= 4'h0;
      seg_dado <= SEG_0;
    end else begin
      if (load) r_digito <= dado;
      seg_dado <= w_seg;
    end
  end

  // In continuous mode the blink counter is held at 0 so it can never wrap into termination
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_estado <= ST_IDLE;
      r_fase   <= '0;
      r_pisca  <= '0;
      sel      <= 1'b0;
      ocupado  <= 1'b0;
    end else if (pisca_stop) begin
      r_estado <= ST_IDLE;
      r_fase   <= '0;
      r_pisca  <= '0;
      sel      <= 1'b0;
      ocupado  <= 1'b0;
    end else begin
      case (r_estado)
        ST_IDLE: begin
          if (pisca_req) begin
            r_estado <= ST_APAGADO;
            r_fase   <= '0;
            r_pisca  <= '0;
            sel      <= 1'b1;
            ocupado  <= 1'b1;
          end
        end
        ST_APAGADO: begin
          if (r_fase == L_FASE_FIM) begin
            r_fase   <= '0;
            r_estado <= ST_ACESO;
            sel      <= 1'b0;
          end else begin
            r_fase <= r_fase + 1'b1;
          end
        end
        ST_ACESO: begin
          if (r_fase == L_FASE_FIM) begin
            r_fase <= '0;
            if (P_NPISCA != 0 && r_pisca == L_PISCA_FIM) begin
              r_estado <= ST_IDLE;
              r_pisca  <= '0;
              ocupado  <= 1'b0;
            end else begin
              r_estado <= ST_APAGADO;
              sel      <= 1'b1;
              if (P_NPISCA != 0) r_pisca <= r_pisca + 1'b1;
            end
          end else begin
            r_fase <= r_fase + 1'b1;
          end
        end
        default: begin
          r_estado <= ST_IDLE;
          r_fase   <= '0;
          r_pisca  <= '0;
          sel      <= 1'b0;
          ocupado  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controle_pisca_7seg.sv
// tb/tb_controle_pisca_7seg.sv - scoreboard bench for controle_pisca_7seg (fixed count and continuous)
module tb_controle_pisca_7seg;

  localparam int DIV = 4;
  localparam int NA  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [3:0] dado = 4'h0;
  logic       pisca_req = 1'b0;
  logic       pisca_stop = 1'b0;

  logic [6:0] seg_a, apag_a, seg_b, apag_b;
  logic       sel_a, oc_a, sel_b, oc_b;

  controle_pisca_7seg #(.P_DIV(DIV), .P_NPISCA(NA)) u_a (
    .clk(clk), .rst(rst), .load(load), .dado(dado),
    .pisca_req(pisca_req), .pisca_stop(pisca_stop),
    .seg_dado(seg_a), .seg_apagado(apag_a), .sel(sel_a), .ocupado(oc_a)
  );

  controle_pisca_7seg #(.P_DIV(DIV), .P_NPISCA(0)) u_b (
    .clk(clk), .rst(rst), .load(load), .dado(dado),
    .pisca_req(pisca_req), .pisca_stop(pisca_stop),
    .seg_dado(seg_b), .seg_apagado(apag_b), .sel(sel_b), .ocupado(oc_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] seg;
    logic       sel_a;
    logic       oc_a;
    logic       sel_b;
    logic       oc_b;
  } esperado_t;

  esperado_t fila[$];

  logic [6:0] tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  int n_checks = 0;
  int n_errors = 0;

  // Reference: a sequence is "busy" for e = 0 .. 2*DIV*N-1 cycles since acceptance; blank when (e/DIV) is even
  int  m_dig = 0;
  bit  m_busy_a = 0, m_busy_b = 0;
  int  m_e_a = 0, m_e_b = 0;

  task automatic chk(input string nome, input logic [6:0] act, input logic [6:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", nome, act, exp, $time);
    end
  endtask

  task automatic avanca(inout bit busy, inout int e, input int n, input logic rq, input logic sp);
    if (sp) busy = 0;
    else if (busy) begin
      e++;
      if (n != 0 && e == 2 * DIV * n) busy = 0;
    end else if (rq) begin
      busy = 1;
      e = 0;
    end
  endtask

  task automatic tick(input logic ld, input logic [3:0] d, input logic rq, input logic sp);
    esperado_t x;
    @(posedge clk);
    #2;
    load = ld; dado = d; pisca_req = rq; pisca_stop = sp;
    x.seg = tab[m_dig];
    if (ld) m_dig = int'(d);
    avanca(m_busy_a, m_e_a, NA, rq, sp);
    avanca(m_busy_b, m_e_b, 0, rq, sp);
    x.sel_a = m_busy_a && ((m_e_a / DIV) % 2 == 0);
    x.oc_a  = m_busy_a;
    x.sel_b = m_busy_b && ((m_e_b / DIV) % 2 == 0);
    x.oc_b  = m_busy_b;
    fila.push_back(x);
  endtask

  task automatic ocioso(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    load = 1'b0; pisca_req = 1'b0; pisca_stop = 1'b0;
    #1;
    chk("rst_seg_a", seg_a, 7'b1000000);
    chk("rst_sel_a", {6'd0, sel_a}, 7'd0);
    chk("rst_oc_a", {6'd0, oc_a}, 7'd0);
    chk("rst_seg_b", seg_b, 7'b1000000);
    chk("rst_sel_b", {6'd0, sel_b}, 7'd0);
    chk("rst_oc_b", {6'd0, oc_b}, 7'd0);
    m_dig = 0; m_busy_a = 0; m_busy_b = 0; m_e_a = 0; m_e_b = 0;
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  initial begin : monitor
    esperado_t x;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && fila.size() > 0) begin
        x = fila.pop_front();
        chk("seg_a", seg_a, x.seg);
        chk("seg_b", seg_b, x.seg);
        chk("sel_a", {6'd0, sel_a}, {6'd0, x.sel_a});
        chk("oc_a", {6'd0, oc_a}, {6'd0, x.oc_a});
        chk("sel_b", {6'd0, sel_b}, {6'd0, x.sel_b});
        chk("oc_b", {6'd0, oc_b}, {6'd0, x.oc_b});
        chk("apagado_a", apag_a, 7'b1111111);
      end
    end
  end

  initial begin : estimulo
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    ocioso(2);

    for (int i = 0; i < 16; i++) tick(1'b1, 4'(i), 1'b0, 1'b0);
    ocioso(2);

    tick(1'b0, 4'h0, 1'b1, 1'b0);
    ocioso(20);
    tick(1'b0, 4'h0, 1'b0, 1'b1);
    ocioso(2);

    tick(1'b0, 4'h0, 1'b1, 1'b1);
    ocioso(3);
    tick(1'b0, 4'h0, 1'b1, 1'b0);
    ocioso(5);
    tick(1'b0, 4'h0, 1'b0, 1'b1);
    ocioso(3);

    tick(1'b0, 4'h0, 1'b1, 1'b0);
    tick(1'b1, 4'h7, 1'b0, 1'b0);
    tick(1'b0, 4'h0, 1'b1, 1'b0);
    ocioso(20);
    tick(1'b0, 4'h0, 1'b0, 1'b1);
    ocioso(2);

    tick(1'b1, 4'h5, 1'b1, 1'b0);
    ocioso(100);
    tick(1'b0, 4'h0, 1'b0, 1'b1);
    ocioso(2);
    tick(1'b0, 4'h0, 1'b1, 1'b0);
    ocioso(49);
    do_reset();
    ocioso(3);

    for (int i = 0; i < 400; i++)
      tick(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 39) == 0));

    @(posedge clk);
    #3;
    chk("fila_vazia", 7'(fila.size()), 7'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
